// File: rtl/sensor_cfg_sequencer.sv
// Boot-time camera configuration sequencer: walks the register LUT after reset and
// issues one I2C write per entry, with NACK retries, a post-soft-reset settle and end-of-table detection.
module sensor_cfg_sequencer #(
  parameter logic [23:0] INIT_DELAY   = 24'd1_000_000,
  parameter logic [15:0] RST_REG_ADDR = 16'h3008,
  parameter logic [23:0] RST_DELAY    = 24'd250_000,
  parameter logic [2:0]  MAX_RETRY    = 3'd3,
  parameter logic [9:0]  MAX_INDEX    = 10'd1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        restart,
  output logic [9:0]  lut_index,
  input  logic [31:0] lut_data,
  output logic        i2c_write_req,
  output logic [7:0]  i2c_slave_addr,
  output logic [15:0] i2c_reg_addr,
  output logic [7:0]  i2c_reg_data,
  input  logic        i2c_done,
  input  logic        i2c_ack_err,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_error,
  output logic [9:0]  cfg_count,
  output logic [3:0]  dbg_state
);

  localparam logic [3:0] S_INIT_WAIT = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_WRITE     = 4'd3;
  localparam logic [3:0] S_WAIT_ACK  = 4'd4;
  localparam logic [3:0] S_SETTLE    = 4'd5;
  localparam logic [3:0] S_NEXT      = 4'd6;
  localparam logic [3:0] S_DONE      = 4'd7;
  localparam logic [3:0] S_FAIL      = 4'd8;

  // A zero delay still costs the one cycle spent in the waiting state.
  localparam logic [23:0] INIT_LAST = (INIT_DELAY == 24'd0) ? 24'd0 : INIT_DELAY - 24'd1;
  localparam logic [23:0] RST_LAST  = (RST_DELAY == 24'd0) ? 24'd0 : RST_DELAY - 24'd1;

  logic [3:0]  state;
  logic [23:0] dly_cnt;
  logic [2:0]  retry;

  assign dbg_state = state;

  // I2C handshake: i2c_write_req is a level that stays high until the master returns a
  // one-cycle i2c_done (i2c_ack_err qualified by it); it drops on the following cycle, and
  // the slave/reg/data fields never change while it is high. One request outstanding at most.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_INIT_WAIT;
      dly_cnt        <= '0;
      retry          <= '0;
      lut_index      <= '0;
      i2c_write_req  <= 1'b0;
      i2c_slave_addr <= '0;
      i2c_reg_addr   <= '0;
      i2c_reg_data   <= '0;
      cfg_busy       <= 1'b1;
      cfg_done       <= 1'b0;
      cfg_error      <= 1'b0;
      cfg_count      <= '0;
    end else begin
      case (state)
        S_INIT_WAIT: begin
          if (dly_cnt == INIT_LAST) begin
            dly_cnt <= '0;
            state   <= S_FETCH;
          end else begin
            dly_cnt <= dly_cnt + 24'd1;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          i2c_slave_addr <= lut_data[31:24];
          i2c_reg_addr   <= lut_data[23:8];
          i2c_reg_data   <= lut_data[7:0];
          retry          <= '0;
          // Both an explicit terminator and an all-zero device address end the table.
          if (lut_data[31:24] == 8'hff || lut_data[31:24] == 8'h00) begin
            cfg_busy <= 1'b0;
            cfg_done <= 1'b1;
            state    <= S_DONE;
          end else begin
            state <= S_WRITE;
          end
        end
        S_WRITE: begin
          i2c_write_req <= 1'b1;
          state         <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (i2c_done) begin
            i2c_write_req <= 1'b0;
            if (!i2c_ack_err) begin
              cfg_count <= cfg_count + 10'd1;
              if (i2c_reg_addr == RST_REG_ADDR) begin
                dly_cnt <= '0;
                state   <= S_SETTLE;
              end else begin
                state <= S_NEXT;
              end
            end else if (retry < MAX_RETRY) begin
              retry <= retry + 3'd1;
              state <= S_WRITE;
            end else begin
              cfg_busy  <= 1'b0;
              cfg_error <= 1'b1;
              state     <= S_FAIL;
            end
          end
        end
        S_SETTLE: begin
          if (dly_cnt == RST_LAST) begin
            dly_cnt <= '0;
            state   <= S_NEXT;
          end else begin
            dly_cnt <= dly_cnt + 24'd1;
          end
        end
        S_NEXT: begin
          // Running off the end of the LUT without a terminator is an error, not a wrap.
          if (lut_index == MAX_INDEX) begin
            cfg_busy  <= 1'b0;
            cfg_error <= 1'b1;
            state     <= S_FAIL;
          end else begin
            lut_index <= lut_index + 10'd1;
            state     <= S_FETCH;
          end
        end
        S_DONE, S_FAIL: begin
          if (restart) begin
            cfg_done  <= 1'b0;
            cfg_error <= 1'b0;
            cfg_count <= '0;
            lut_index <= '0;
            cfg_busy  <= 1'b1;
            dly_cnt   <= '0;
            state     <= S_INIT_WAIT;
          end
        end
        default: begin
          i2c_write_req <= 1'b0;
          cfg_busy      <= 1'b0;
          cfg_error     <= 1'b1;
          state         <= S_FAIL;
        end
      endcase
    end
  end

endmodule
